branch_predict_unit: RTL and testbench

//  Parametrised fetch-stage branch predictor for the 5-stage pipeline: a direct-mapped BTB with
//  per-entry saturating counters, plus a return-address stack (RAS) for jal/jr $31.

---
 rtl/diaosi_types_pkg.sv | 17 +
 rtl/return_addr_stack.sv | 55 +++++
 rtl/branch_predict_unit.sv | 148 ++++++++++++++
 tb/tb_branch_predict_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diaosi_types_pkg.sv
// Shared types for the fetch-stage branch predictor: control-flow kinds and predictor modes.
package diaosi_types_pkg;

    typedef enum logic [1:0] {
        BR   = 2'd0,
        J    = 2'd1,
        JAL  = 2'd2,
        JR31 = 2'd3
    } br_kind_t;

    typedef enum int {
        BPRED_STATIC    = 0,
        BPRED_BIMODAL   = 1,
        BPRED_BTB_TAKEN = 2
    } bpred_mode_t;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a push when full overwrites the oldest slot, a pop when empty is ignored.
module return_addr_stack #(
    parameter int RAS_DEPTH = 4,
    parameter int DATA_W    = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [DATA_W-1:0] slot_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (PTR_W+1)'(RAS_DEPTH));
    assign top   = slot_q[ptr_q - PTR_W'(1)];

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (!full) cnt_d = cnt_q + (PTR_W+1)'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - (PTR_W+1)'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: slot storage is deliberately not reset; cnt_q gates every read, so stale data is never used.
    always_ff @(posedge CLK) begin
        if (push && !RST) slot_q[ptr_q] <= push_data;
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-stage branch predictor: direct-mapped flop BTB with saturating counters plus a RAS for jal/jr $31.
// Lookup is combinational at IF; training, RAS maintenance and perf counters are driven from EX resolution.
module branch_predict_unit
    import diaosi_types_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int ENTRIES   = 16,
    parameter int CNT_W     = 2,
    parameter int RAS_DEPTH = 4,
    parameter int MODE      = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [1:0]      upd_kind,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [PC_W-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [31:0]     hit_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam int               IDX_W    = $clog2(ENTRIES);
    localparam int               TAG_W    = PC_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CTR_MAX  = '1;
    localparam logic [CNT_W-1:0] CTR_WEAK = CTR_MAX ^ (CTR_MAX >> 1);
    localparam bpred_mode_t      MODE_E   = bpred_mode_t'(MODE);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        br_kind_t         kind;
        logic [CNT_W-1:0] ctr;
    } bpred_entry_t;

    bpred_entry_t     btb_q [ENTRIES];
    bpred_entry_t     up_entry, up_entry_d;
    logic             btb_we;
    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit, lk_dir;
    br_kind_t         upd_kind_e;
    logic [PC_W-1:0]  ras_top;
    logic             ras_empty, ras_full_unused;
    logic [31:0]      hit_cnt_q, hit_cnt_d, mispred_cnt_q, mispred_cnt_d;

    assign upd_kind_e = br_kind_t'(upd_kind);
    assign lk_idx     = lookup_pc[IDX_W+1:2];
    assign lk_tag     = lookup_pc[PC_W-1:IDX_W+2];
    assign up_idx     = upd_pc[IDX_W+1:2];
    assign up_tag     = upd_pc[PC_W-1:IDX_W+2];
    assign lk_hit     = btb_q[lk_idx].valid && (btb_q[lk_idx].tag == lk_tag);
    assign up_entry   = btb_q[up_idx];
    assign up_hit     = up_entry.valid && (up_entry.tag == up_tag);

    always_comb begin
        case (MODE_E)
            BPRED_BIMODAL:   lk_dir = lk_hit && ((btb_q[lk_idx].kind != BR) || btb_q[lk_idx].ctr[CNT_W-1]);
            BPRED_BTB_TAKEN: lk_dir = lk_hit;
            default:         lk_dir = 1'b0;
        endcase
    end

    always_comb begin
        pred_taken  = lk_dir && !RST;
        pred_target = lookup_pc + PC_W'(4);
        if (lk_dir && !RST) begin
            if ((btb_q[lk_idx].kind == JR31) && !ras_empty) pred_target = ras_top;
            else                                            pred_target = btb_q[lk_idx].target;
        end
    end

    assign mispredict = upd_valid && !RST &&
                        ((upd_taken != upd_pred_taken) || (upd_taken && (upd_target != upd_pred_target)));

    // Training: a hit retrains in place, a taken miss allocates over whatever lives at the index.
    always_comb begin
        up_entry_d = up_entry;
        btb_we     = 1'b0;
        if (upd_valid) begin
            if (up_hit) begin
                btb_we            = 1'b1;
                up_entry_d.target = upd_target;
                up_entry_d.kind   = upd_kind_e;
                if (upd_taken && (up_entry.ctr != CTR_MAX))
                    up_entry_d.ctr = up_entry.ctr + CNT_W'(1);
                else if (!upd_taken && (up_entry.ctr != '0))
                    up_entry_d.ctr = up_entry.ctr - CNT_W'(1);
            end else if (upd_taken) begin
                btb_we            = 1'b1;
                up_entry_d.valid  = 1'b1;
                up_entry_d.tag    = up_tag;
                up_entry_d.target = upd_target;
                up_entry_d.kind   = upd_kind_e;
                up_entry_d.ctr    = CTR_WEAK;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i].valid <= 1'b0;
                btb_q[i].ctr   <= '0;
            end
        end else if (btb_we) begin
            btb_q[up_idx] <= up_entry_d;
        end
    end

    assign hit_cnt_d     = (upd_valid && up_hit && (hit_cnt_q != '1)) ? hit_cnt_q + 32'd1 : hit_cnt_q;
    assign mispred_cnt_d = (mispredict && (mispred_cnt_q != '1)) ? mispred_cnt_q + 32'd1 : mispred_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            hit_cnt_q     <= hit_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign hit_cnt     = hit_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

    return_addr_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .DATA_W    (PC_W)
    ) u_ras (
        .CLK       (CLK),
        .RST       (RST),
        .push      (upd_valid && (upd_kind_e == JAL)),
        .pop       (upd_valid && (upd_kind_e == JR31)),
        .push_data (upd_pc + PC_W'(4)),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full_unused)
    );

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural BTB/RAS model.
module tb_branch_predict_unit;
    import diaosi_types_pkg::*;

    localparam int PC_W      = 32;
    localparam int ENTRIES   = 16;
    localparam int CNT_W     = 2;
    localparam int RAS_DEPTH = 4;
    localparam int MODE      = 1;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [1:0]  upd_kind;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] hit_cnt;
    logic [31:0] mispred_cnt;

    always #5 CLK = ~CLK;

    branch_predict_unit #(
        .PC_W      (PC_W),
        .ENTRIES   (ENTRIES),
        .CNT_W     (CNT_W),
        .RAS_DEPTH (RAS_DEPTH),
        .MODE      (MODE)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .lookup_pc       (lookup_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_kind        (upd_kind),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .hit_cnt         (hit_cnt),
        .mispred_cnt     (mispred_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        else             n_pass++;
    endtask

    // Behavioural model: each slot remembers the full PC that owns it; counters are plain ints.
    bit          m_valid [ENTRIES];
    logic [31:0] m_pc    [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_kind  [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_ras [$];
    longint      m_hits = 0;
    longint      m_mis  = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 32'(ENTRIES));
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i = idx_of(pc);
        return m_valid[i] && ((m_pc[i] >> 6) == (pc >> 6));
    endfunction

    function automatic bit exp_mis();
        return upd_valid && !RST &&
               ((upd_taken != upd_pred_taken) || (upd_taken && (upd_target != upd_pred_target)));
    endfunction

    task automatic exp_pred(output bit t, output logic [31:0] tg);
        int i = idx_of(lookup_pc);
        t  = 1'b0;
        tg = lookup_pc + 32'd4;
        if (!RST && m_hit(lookup_pc) && (m_kind[i] != int'(BR) || m_ctr[i] >= 2)) begin
            t  = 1'b1;
            tg = (m_kind[i] == int'(JR31) && m_ras.size() > 0) ? m_ras[$] : m_tgt[i];
        end
    endtask

    always @(posedge CLK) begin : model_update
        int i;
        bit h;
        if (RST) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 0;
            end
            m_ras.delete();
            m_hits = 0;
            m_mis  = 0;
        end else if (upd_valid) begin
            i = idx_of(upd_pc);
            h = m_hit(upd_pc);
            if (h && m_hits < 64'hFFFF_FFFF) m_hits++;
            if (exp_mis() && m_mis < 64'hFFFF_FFFF) m_mis++;
            if (h) begin
                m_ctr[i]  = upd_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                      : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                m_tgt[i]  = upd_target;
                m_kind[i] = int'(upd_kind);
            end else if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_pc[i]    = upd_pc;
                m_tgt[i]   = upd_target;
                m_kind[i]  = int'(upd_kind);
                m_ctr[i]   = 2;
            end
            if (upd_kind == JAL) begin
                m_ras.push_back(upd_pc + 32'd4);
                if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
            end else if (upd_kind == JR31 && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
        end
    end

    always @(negedge CLK) begin : compare
        bit          t;
        logic [31:0] tg;
        if (chk_en) begin
            exp_pred(t, tg);
            check("pred_taken",  pred_taken,  t);
            check("pred_target", pred_target, tg);
            check("mispredict",  mispredict,  exp_mis());
            check("hit_cnt",     hit_cnt,     m_hits);
            check("mispred_cnt", mispred_cnt, m_mis);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input br_kind_t k, input bit tk,
                       input logic [31:0] tg, input bit ptk, input logic [31:0] ptg);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_kind        = k;
        upd_taken       = tk;
        upd_target      = tg;
        upd_pred_taken  = ptk;
        upd_pred_target = ptg;
    endtask

    logic [31:0] pc_pool  [8] = '{32'h40, 32'h80, 32'h1010, 32'h2000, 32'h44, 32'h84, 32'hFFFF_FFFC, 32'h10};
    logic [31:0] tgt_pool [4] = '{32'h80, 32'h200, 32'h1234, 32'h3000};
    logic [31:0] pop_exp  [5] = '{32'h404, 32'h304, 32'h204, 32'h1234, 32'h1234};

    initial begin
        RST = 1'b1;
        lookup_pc = 32'h40;
        upd_valid = 1'b0; upd_pc = '0; upd_kind = BR; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        repeat (2) tick();
        chk_en = 1'b1;
        RST = 1'b0;
        tick();

        // Out of reset: cold miss.
        lookup_pc = 32'h40; #1;
        check("t1 taken", pred_taken, 1'b0);
        check("t1 target", pred_target, 32'h44);
        check("t1 hit_cnt", hit_cnt, 32'd0);
        check("t1 mispred_cnt", mispred_cnt, 32'd0);

        // Taken BR allocates weakly-taken.
        upd(32'h40, BR, 1'b1, 32'h80, 1'b0, 32'h44); #1;
        check("t2 mispredict", mispredict, 1'b1);
        tick(); upd_valid = 1'b0; #1;
        check("t2 taken", pred_taken, 1'b1);
        check("t2 target", pred_target, 32'h80);
        check("t2 mispred_cnt", mispred_cnt, 32'd1);

        // Three not-taken: ctr 2->1->0->0.
        upd(32'h40, BR, 1'b0, 32'h80, 1'b1, 32'h80); #1;
        check("t3 mispredict a", mispredict, 1'b1);
        tick(); upd_valid = 1'b0; #1;
        check("t3 taken a", pred_taken, 1'b0);
        for (int n = 0; n < 2; n++) begin
            upd(32'h40, BR, 1'b0, 32'h80, 1'b0, 32'h44); #1;
            check("t3 mispredict b", mispredict, 1'b0);
            tick(); upd_valid = 1'b0; #1;
            check("t3 taken b", pred_taken, 1'b0);
        end
        check("t3 mispred_cnt", mispred_cnt, 32'd2);
        check("t3 hit_cnt", hit_cnt, 32'd3);
        // From 0, one taken gives 1 (still not-taken); a second gives 2.
        upd(32'h40, BR, 1'b1, 32'h80, 1'b0, 32'h44);
        tick(); upd_valid = 1'b0; #1;
        check("t3 taken c", pred_taken, 1'b0);
        upd(32'h40, BR, 1'b1, 32'h80, 1'b0, 32'h44);
        tick(); upd_valid = 1'b0; #1;
        check("t3 taken d", pred_taken, 1'b1);
        check("t3 hit_cnt d", hit_cnt, 32'd5);

        // Alias: 0x80 shares index 0 with 0x40.
        upd(32'h80, BR, 1'b1, 32'h200, 1'b0, 32'h84);
        tick(); upd_valid = 1'b0; #1;
        check("t4 alias taken", pred_taken, 1'b0);
        check("t4 alias target", pred_target, 32'h44);
        lookup_pc = 32'h80; #1;
        check("t4 new taken", pred_taken, 1'b1);
        check("t4 new target", pred_target, 32'h200);

        // RAS: JR31 entry first, then five JALs overflow a depth-4 stack.
        lookup_pc = 32'h1010;
        upd(32'h1010, JR31, 1'b1, 32'h1234, 1'b0, 32'h1014);
        tick(); upd_valid = 1'b0; #1;
        check("t5 empty-ras target", pred_target, 32'h1234);
        for (int n = 1; n <= 5; n++) begin
            upd(32'h100 * n, JAL, 1'b1, 32'h3000, 1'b1, 32'h3000);
            tick();
        end
        upd_valid = 1'b0; #1;
        check("t5 ras top", pred_target, 32'h504);
        for (int n = 0; n < 5; n++) begin
            upd(32'h1010, JR31, 1'b1, 32'h1234, 1'b1, 32'h1234);
            tick(); upd_valid = 1'b0; #1;
            check("t5 after pop", pred_target, pop_exp[n]);
        end
        upd(32'h700, JAL, 1'b1, 32'h3000, 1'b1, 32'h3000);
        tick(); upd_valid = 1'b0; #1;
        check("t5 push after underflow", pred_target, 32'h704);

        // Mid-run reset with a live entry.
        RST = 1'b1;
        upd(32'h40, BR, 1'b1, 32'h80, 1'b0, 32'h0); #1;
        check("t6 rst taken", pred_taken, 1'b0);
        check("t6 rst target", pred_target, 32'h1014);
        check("t6 rst mispredict", mispredict, 1'b0);
        tick(); RST = 1'b0; upd_valid = 1'b0; #1;
        check("t6 post taken", pred_taken, 1'b0);
        check("t6 post target", pred_target, 32'h1014);
        check("t6 post hit_cnt", hit_cnt, 32'd0);
        check("t6 post mispred_cnt", mispred_cnt, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            br_kind_t    k;
            logic [31:0] tg;
            bit          tk;
            RST       = ($urandom_range(0, 299) == 0);
            lookup_pc = pc_pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            k         = br_kind_t'($urandom_range(0, 3));
            tk        = (k != BR) ? 1'b1 : 1'($urandom_range(0, 1));
            tg        = tgt_pool[$urandom_range(0, 3)];
            upd(pc_pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)), k, tk, tg,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? tg : tgt_pool[$urandom_range(0, 3)]);
            upd_valid = ($urandom_range(0, 3) != 0);
            tick();
        end
        RST = 1'b0;
        upd_valid = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
